// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin arbiter that shares one uart_tx transmitter between several
// word producers. It captures one word at a time from the winning requester
// and offers it to the transmitter. It then follows the transmitter's ready
// signal to know when the word has been taken and the line is free again.
// A requester can lock ownership across consecutive words, so multi-byte
// messages are not interleaved with other requesters' words.
//
// Ports:
//   clock_i        single clock, shared with the uart_tx instance
//   reset_i        synchronous, active-high reset
//   req_valid_i    per-requester "has a word"
//   req_lock_i     per-requester "keep ownership for the next word", taken
//                  together with the accepted word
//   req_data_i     word of requester i at bits [i*width +: width]
//   req_ready_o    one-hot grant; a transfer happens when valid && ready
//   tx_ready_i     transmitter ready
//   tx_can_send_o  to transmitter can_send_next_word
//   tx_data_o      to transmitter data
//   busy_o         arbiter is not idle
//   owner_o        index of the last accepted requester
//   locked_o       ownership is held by owner_o

module uart_tx_arbiter #(
  parameter int num_requesters = 4,
  parameter int width          = 8,
  localparam int IdxW          = $clog2(num_requesters)
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic [num_requesters-1:0]        req_valid_i,
  input  logic [num_requesters-1:0]        req_lock_i,
  input  logic [num_requesters*width-1:0]  req_data_i,
  output logic [num_requesters-1:0]        req_ready_o,
  input  logic                             tx_ready_i,
  output logic                             tx_can_send_o,
  output logic [width-1:0]                 tx_data_o,
  output logic                             busy_o,
  output logic [IdxW-1:0]                  owner_o,
  output logic                             locked_o
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    BUSY
  } state_t;

  localparam logic [IdxW:0]   SumN    = (IdxW+1)'(num_requesters);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(num_requesters - 1);

  state_t            state_q;
  logic              tx_can_send_q;
  logic [width-1:0]  tx_data_q;
  logic [IdxW-1:0]   owner_q;
  logic              locked_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   ptr_d;

  logic              grant_found;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW:0]     cand_sum;
  logic              accept;
  logic [width-1:0]  grant_data;

  // Candidate selection. While locked only the owner can be chosen, even if
  // it currently has no word. Otherwise the search walks upward from the
  // pointer; iterating from the farthest candidate down to the pointer
  // itself lets the nearest valid requester overwrite the earlier hits.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    if (locked_q) begin
      grant_found = 1'b1;
      grant_idx   = owner_q;
    end else begin
      for (int k = num_requesters - 1; k >= 0; k--) begin
        cand_sum = {1'b0, ptr_q} + (IdxW+1)'(k);
        if (cand_sum >= SumN) begin
          cand_sum = cand_sum - SumN;
        end
        if (req_valid_i[cand_sum[IdxW-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand_sum[IdxW-1:0];
        end
      end
    end
  end

  // Grant is only advertised in IDLE while the transmitter reports ready.
  always_comb begin
    req_ready_o = '0;
    if ((state_q == IDLE) && tx_ready_i && grant_found) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign accept     = (state_q == IDLE) && tx_ready_i && grant_found && req_valid_i[grant_idx];
  assign grant_data = req_data_i[grant_idx*width +: width];
  assign ptr_d      = (grant_idx == LastIdx) ? '0 : grant_idx + IdxW'(1);

  // Main FSM. tx_can_send is held from acceptance until the transmitter is
  // seen not ready; this also covers the stop-bit countdown, during which
  // the transmitter reports ready but does not take a new word.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      tx_can_send_q <= 1'b0;
      tx_data_q     <= '0;
      owner_q       <= '0;
      locked_q      <= 1'b0;
      ptr_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tx_data_q     <= grant_data;
            owner_q       <= grant_idx;
            locked_q      <= req_lock_i[grant_idx];
            ptr_q         <= ptr_d;
            tx_can_send_q <= 1'b1;
            state_q       <= OFFER;
          end
        end
        OFFER: begin
          if (!tx_ready_i) begin
            tx_can_send_q <= 1'b0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (tx_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_can_send_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign tx_can_send_o = tx_can_send_q;
  assign tx_data_o     = tx_data_q;
  assign busy_o        = (state_q != IDLE);
  assign owner_o       = owner_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with four requesters and 8-bit words.
// A small uart_tx model (4 clocks per bit) takes words from the arbiter and
// drives a serial line. A line receiver decodes the frames back into bytes.
// Expected grant orders and line bytes are written out by hand for each step.

module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  reqValid;
  logic [3:0]  reqLock;
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic        txReady;
  logic        txCanSend;
  logic [7:0]  txData;
  logic        busy;
  logic [1:0]  owner;
  logic        locked;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .num_requesters(4),
    .width(8)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .req_valid_i(reqValid),
    .req_lock_i(reqLock),
    .req_data_i(reqData),
    .req_ready_o(reqReady),
    .tx_ready_i(txReady),
    .tx_can_send_o(txCanSend),
    .tx_data_o(txData),
    .busy_o(busy),
    .owner_o(owner),
    .locked_o(locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Transmitter model: ready while idle and during the stop bit, but a new
  // word is only taken from idle.
  typedef enum logic [1:0] {M_IDLE, M_START, M_DATA, M_STOP} mstate_t;
  mstate_t    mState;
  logic [1:0] mCnt;
  logic [2:0] mBit;
  logic [7:0] mShift;
  logic       line;
  int         takeCount = 0;

  assign txReady = (mState == M_IDLE) || (mState == M_STOP);

  always @(posedge clock) begin
    if (reset) begin
      mState <= M_IDLE;
      mCnt   <= 2'd0;
      mBit   <= 3'd0;
      line   <= 1'b1;
    end else begin
      case (mState)
        M_IDLE: begin
          if (txCanSend) begin
            mShift    <= txData;
            takeCount <= takeCount + 1;
            line      <= 1'b0;
            mCnt      <= 2'd0;
            mState    <= M_START;
          end
        end
        M_START: begin
          if (mCnt == 2'd3) begin
            mCnt   <= 2'd0;
            mBit   <= 3'd0;
            line   <= mShift[0];
            mState <= M_DATA;
          end else begin
            mCnt <= mCnt + 2'd1;
          end
        end
        M_DATA: begin
          if (mCnt == 2'd3) begin
            mCnt <= 2'd0;
            if (mBit == 3'd7) begin
              line   <= 1'b1;
              mState <= M_STOP;
            end else begin
              mBit <= mBit + 3'd1;
              line <= mShift[mBit + 3'd1];
            end
          end else begin
            mCnt <= mCnt + 2'd1;
          end
        end
        default: begin
          if (mCnt == 2'd3) begin
            mCnt   <= 2'd0;
            mState <= M_IDLE;
          end else begin
            mCnt <= mCnt + 2'd1;
          end
        end
      endcase
    end
  end

  // Line receiver: sample each bit in the middle of its 4-clock period.
  logic       rxActive;
  int         rxR;
  logic [7:0] rxShift;
  logic [7:0] lineQ[$];
  int         framingErrs = 0;

  always @(posedge clock) begin
    if (reset) begin
      rxActive <= 1'b0;
      rxR      <= 0;
    end else if (!rxActive) begin
      if (line == 1'b0) begin
        rxActive <= 1'b1;
        rxR      <= 1;
      end
    end else begin
      rxR <= rxR + 1;
      if (rxR == 2 && line !== 1'b0) framingErrs <= framingErrs + 1;
      if (rxR >= 6 && rxR <= 34 && ((rxR - 6) % 4) == 0) rxShift[(rxR - 6) / 4] <= line;
      if (rxR == 38) begin
        rxActive <= 1'b0;
        if (line === 1'b1) lineQ.push_back(rxShift);
        else framingErrs <= framingErrs + 1;
      end
    end
  end

  // Grant recorder: index of every completed handshake.
  int grantQ[$];

  always @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        if (reqValid[k] && reqReady[k]) grantQ.push_back(k);
      end
    end
  end

  // Hold and lock-window observers, evaluated between edges.
  logic       prevCanSend = 1'b0;
  logic       prevReady = 1'b0;
  logic       prevReset = 1'b1;
  logic [7:0] prevData = 8'h00;
  int         holdViol = 0;
  int         lockViol = 0;
  int         stopHold = 0;

  always @(negedge clock) begin
    if (!reset && !prevReset && prevCanSend) begin
      if (prevReady && (!txCanSend || txData !== prevData)) holdViol <= holdViol + 1;
      if (!prevReady && txCanSend) holdViol <= holdViol + 1;
    end
    if (locked && (reqReady[0] || reqReady[3])) lockViol <= lockViol + 1;
    if (txCanSend && mState == M_STOP) stopHold <= stopHold + 1;
    prevCanSend <= txCanSend;
    prevReady   <= txReady;
    prevReset   <= reset;
    prevData    <= txData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] lock, input logic [31:0] data);
    reqValid = valid;
    reqLock  = lock;
    reqData  = data;
  endtask

  task automatic waitAccepts(input int n, input string tag);
    int budget = 0;
    while (grantQ.size() < n && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    assert (grantQ.size() >= n) else begin
      errors++;
      $error("[TB] FAIL %s: accepts=%0d required=%0d", tag, grantQ.size(), n);
    end
  endtask

  task automatic waitLineBytes(input int n, input string tag);
    int budget = 0;
    while ((lineQ.size() < n || busy) && budget < 3000) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    assert (lineQ.size() >= n && !busy) else begin
      errors++;
      $error("[TB] FAIL %s: lineBytes=%0d required=%0d", tag, lineQ.size(), n);
    end
  endtask

  task automatic waitReady(input logic level, input string tag);
    int budget = 0;
    while (txReady !== level && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    assert (txReady === level) else begin
      errors++;
      $error("[TB] FAIL %s: txReady=%0b required=%0b", tag, txReady, level);
    end
  endtask

  task automatic checkGrant(input int i, input int expected, input string tag);
    checkOutput(tag, (grantQ.size() > i) ? grantQ[i] : 99, expected);
  endtask

  task automatic checkByte(input int i, input logic [7:0] expected, input string tag);
    checkOutput(tag, (lineQ.size() > i) ? {24'h0, lineQ[i]} : 32'hDEAD, {24'h0, expected});
  endtask

  int takeSnap;
  int stopSnap;

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    repeat (3) @(negedge clock);

    checkOutput("rstCanSend", txCanSend, 0);
    checkOutput("rstTxData", txData, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOwner", owner, 0);
    checkOutput("rstLocked", locked, 0);
    checkOutput("rstReqReady", reqReady, 0);
    reset = 1'b0;

    // Reset in the middle of an offer drops the word.
    applyStimulus(4'b0010, 4'b0000, 32'h0000_7700);
    @(negedge clock);
    checkOutput("offerCanSend", txCanSend, 1);
    checkOutput("offerOwner", owner, 1);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    @(negedge clock);
    checkOutput("midRstCanSend", txCanSend, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstReqReady", reqReady, 0);
    checkOutput("midRstOwner", owner, 0);
    checkOutput("midRstLocked", locked, 0);
    checkOutput("midRstTxData", txData, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("midRstNoTake", takeCount, 0);

    // Round robin from pointer 0 with everyone valid.
    grantQ.delete();
    lineQ.delete();
    applyStimulus(4'b1111, 4'b0000, 32'h1312_1110);
    waitAccepts(5, "rrAccepts");
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    waitLineBytes(5, "rrLine");
    checkGrant(0, 0, "rrGrant0");
    checkGrant(1, 1, "rrGrant1");
    checkGrant(2, 2, "rrGrant2");
    checkGrant(3, 3, "rrGrant3");
    checkGrant(4, 0, "rrGrant4");
    checkByte(0, 8'h10, "rrByte0");
    checkByte(1, 8'h11, "rrByte1");
    checkByte(2, 8'h12, "rrByte2");
    checkByte(3, 8'h13, "rrByte3");
    checkByte(4, 8'h10, "rrByte4");

    // Lock: pointer is 1, requester 1 keeps ownership for two words.
    grantQ.delete();
    lineQ.delete();
    applyStimulus(4'b1011, 4'b0010, 32'h4300_3140);
    waitAccepts(1, "lockAcc1");
    checkOutput("lockSet", locked, 1);
    checkOutput("lockOwner", owner, 1);
    applyStimulus(4'b1011, 4'b0000, 32'h4300_3240);
    waitAccepts(2, "lockAcc2");
    checkOutput("lockCleared", locked, 0);
    applyStimulus(4'b1001, 4'b0000, 32'h4300_0040);
    waitAccepts(4, "lockAcc4");
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    waitLineBytes(4, "lockLine");
    checkGrant(0, 1, "lockGrant0");
    checkGrant(1, 1, "lockGrant1");
    checkGrant(2, 3, "lockGrant2");
    checkGrant(3, 0, "lockGrant3");
    checkByte(0, 8'h31, "lockByte0");
    checkByte(1, 8'h32, "lockByte1");
    checkByte(2, 8'h43, "lockByte2");
    checkByte(3, 8'h40, "lockByte3");
    checkOutput("lockWindow", lockViol, 0);

    // Single word from requester 2 (pointer is 1).
    grantQ.delete();
    lineQ.delete();
    takeSnap = takeCount;
    applyStimulus(4'b0100, 4'b0000, 32'h00A5_0000);
    #1;
    checkOutput("swReqReady", reqReady, 4'b0100);
    @(negedge clock);
    checkOutput("swReqReadyOff", reqReady, 0);
    checkOutput("swCanSend", txCanSend, 1);
    checkOutput("swTxData", txData, 8'hA5);
    checkOutput("swOwner", owner, 2);
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    @(negedge clock);
    checkOutput("swReadyLow", txReady, 0);
    checkOutput("swCanSendHeld", txCanSend, 1);
    @(negedge clock);
    checkOutput("swCanSendDrop", txCanSend, 0);
    checkOutput("swBusy", busy, 1);
    waitReady(1'b1, "swReadyRise");
    checkOutput("swBusyAtRise", busy, 1);
    @(negedge clock);
    checkOutput("swBusyFall", busy, 0);
    waitLineBytes(1, "swLine");
    checkByte(0, 8'hA5, "swByte");
    checkOutput("swTakes", takeCount - takeSnap, 1);

    // Wrap-around: pointer 3, requesters 0 and 3 valid.
    grantQ.delete();
    lineQ.delete();
    applyStimulus(4'b1001, 4'b0000, 32'h6300_0060);
    waitAccepts(2, "wrapAcc");
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    waitLineBytes(2, "wrapLine");
    checkGrant(0, 3, "wrapGrant0");
    checkGrant(1, 0, "wrapGrant1");
    checkByte(0, 8'h63, "wrapByte0");
    checkByte(1, 8'h60, "wrapByte1");

    // Pointer 1, only requester 0 valid.
    grantQ.delete();
    lineQ.delete();
    applyStimulus(4'b0001, 4'b0000, 32'h0000_0061);
    waitAccepts(1, "wrap2Acc");
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    waitLineBytes(1, "wrap2Line");
    checkGrant(0, 0, "wrap2Grant");
    checkByte(0, 8'h61, "wrap2Byte");

    // Stop-bit hold: next word offered as soon as ready rises.
    grantQ.delete();
    lineQ.delete();
    takeSnap = takeCount;
    stopSnap = stopHold;
    applyStimulus(4'b0100, 4'b0000, 32'h005A_0000);
    waitAccepts(1, "stopAcc1");
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    waitReady(1'b0, "stopTaken");
    waitReady(1'b1, "stopRise");
    applyStimulus(4'b1000, 4'b0000, 32'hC300_0000);
    waitAccepts(2, "stopAcc2");
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    waitLineBytes(2, "stopLine");
    repeat (60) @(negedge clock);
    checkGrant(0, 2, "stopGrant0");
    checkGrant(1, 3, "stopGrant1");
    checkByte(0, 8'h5A, "stopByte0");
    checkByte(1, 8'hC3, "stopByte1");
    checkOutput("stopLineCount", lineQ.size(), 2);
    checkOutput("stopTakes", takeCount - takeSnap, 2);
    checkOutput("stopHeld", (stopHold - stopSnap) > 0, 1);

    // Idle requesters: nothing moves.
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleCanSend", txCanSend, 0);
    checkOutput("holdRule", holdViol, 0);
    checkOutput("framing", framingErrs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single `uart_tx` transmitter between `num_requesters` word producers. It captures one word at a time from the winning requester and drives the transmitter's `can_send_next_word`/`data` inputs. It then tracks the transmitter's `ready` output to know when the word has been taken and the line is free again. An optional per-requester lock keeps ownership across consecutive words, so multi-byte messages are not interleaved. Sits between the producer blocks and the `uart_tx` instance.

## Interface
- `num_requesters`, default 4: number of requester ports; ≥2.
- `width`, default 8: word width; equals the transmitter's `width`.
- `clock`  in  1: single clock, same as the `uart_tx` instance.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  num_requesters: requester i has a word.
- `req_lock`  in  num_requesters: sampled with the accepted word; 1 = keep ownership for the next word.
- `req_data`  in  num_requesters*width: word of requester i at bits [i*width +: width].
- `req_ready`  out  num_requesters: one-hot; transfer from requester i when `req_valid[i] && req_ready[i]` at a rising edge.
- `tx_ready`  in  1: transmitter `ready`.
- `tx_can_send`  out  1: to transmitter `can_send_next_word`.
- `tx_data`  out  width: to transmitter `data`.
- `busy`  out  1: state ≠ IDLE.
- `owner`  out  $clog2(num_requesters): index of the last accepted requester.
- `locked`  out  1: ownership is held by `owner`.

## Operation
- **Reset values:** state IDLE; `tx_can_send`=0, `tx_data`=0, `req_ready`=0, `busy`=0, `owner`=0, `locked`=0, rr pointer=0.
- **Reset priority:** reset wins over all events. It aborts any state immediately; an offered word is dropped.
- **IDLE:**
  - If `tx_ready`=1, compute the grant combinationally.
  - If `locked`: the candidate is `owner` only; other requesters are never granted, even if `owner` is not valid.
  - Else: the first asserted `req_valid` at or after the pointer, searching upward modulo `num_requesters`.
  - `req_ready[g]`=1 for the granted g only; all bits are 0 if there is no candidate or `tx_ready`=0.
- **Acceptance (IDLE edge with `req_valid[g]`):** `tx_data` <= `req_data[g]`, `owner` <= g, `locked` <= `req_lock[g]`. The pointer becomes g+1 modulo `num_requesters` (it wraps from num_requesters-1 to 0). State goes to OFFER.
- **OFFER:** `tx_can_send`=1, `tx_data` held stable. Stay until `tx_ready`=0 is sampled, then go to BUSY. Holding `tx_can_send` covers the transmitter's stop-bit countdown, during which `ready`=1 but no word is taken.
- **BUSY:** `tx_can_send`=0. Stay until `tx_ready`=1 is sampled, then go to IDLE.
- **`req_ready` outside IDLE:** all bits are 0 in OFFER and BUSY; requesters may change `req_valid` and `req_data` freely.
- **Lock release:** a locked owner releases ownership by submitting a word with `req_lock`=0. That word is still sent; arbitration resumes from the pointer afterwards.
- **Unlocked ownership:** `req_lock` is ignored while not owning.

## Timing
- **Accept to offer:** the acceptance edge is at t; `tx_can_send`=1 from cycle t+1.
- **Back-to-back throughput:**
  - Minimum cycle count is IDLE (1) + OFFER (≥1) + BUSY (≥1) per word.
  - Actual throughput is bounded by the transmitter frame time: 10 bit periods of clock_freq/baud_rate cycles each.
- **Hold rule:** `tx_can_send` and `tx_data` are registered, glitch-free, and remain constant from OFFER entry until the edge where `tx_ready`=0 is sampled.
- **Simultaneous requests:** the lowest index at or above the pointer wins. After a grant to i, the next search starts at i+1.
- **Pointer update:** the pointer changes only on acceptance.
- **Idle requesters:** with no valid requester, stay in IDLE indefinitely; outputs are static.

## Test plan
- **Reset:** assert `reset` mid-OFFER with `tx_can_send`=1. Required next cycle: `tx_can_send`=0, `busy`=0, `req_ready`=0, `owner`=0, `locked`=0.
- **Single word:** req 2 sends 8'hA5, with a `uart_tx` model at ticks_per_bit=4. Required:
  - `req_ready`=4'b0100 for one cycle;
  - `tx_can_send` high from the next cycle until `tx_ready` falls;
  - the line carries start, A5 LSB-first, stop;
  - `busy` falls after `tx_ready` rises.
- **Round-robin:** all 4 requesters hold valid continuously, words 8'h10..8'h13. Required grant order 0,1,2,3,0 and line bytes 10,11,12,13,10.
- **Lock:**
  - req 1 sends 8'h31 (lock=1) and 8'h32 (lock=0), while reqs 0 and 3 are valid throughout.
  - Required order: 31, 32, 3's word, 0's word.
  - `locked`=1 only between the two accepts, and reqs 0 and 3 see `req_ready`=0 in that window.
- **Stop-bit hold:** submit the next word immediately after `tx_ready` rises. Required: `tx_can_send` stays high through the whole stop-bit countdown and the word is taken exactly once, with no duplicated or lost byte.
- **Wrap-around:** pointer=3, valid on reqs 0 and 3. Required grant 3 then 0; with only req 0 valid and pointer=1, grant 0.
